// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard/issue controller.
// The HAZARD_FWD_EN build option is consumed in hazard_ctrl.sv.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_C   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_e;

    // Entry vectors are ordered {W, C, A}.
    localparam logic [2:0] ENT_A_MASK       = 3'b001;
    localparam logic [2:0] NOFWD_STALL_MASK = 3'b011;

    // Youngest producer wins; a W-only hit reads the write-first regfile.
    function automatic fwd_sel_e fwd_pick(input logic [2:0] m);
        fwd_sel_e sel;
        casez (m)
            3'b??1:  sel = FWD_C;
            3'b?10:  sel = FWD_W;
            default: sel = FWD_REG;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_hz_match.sv
// Compares one D source index against one scoreboard entry.
module hz_match
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             src_used_i,
    input  logic             ent_valid_i,
    input  logic [REG_W-1:0] ent_rd_i,
    input  logic             ent_we_i,
    input  logic             ent_load_i,
    output logic             match_o,
    output logic             is_load_o
);

    assign match_o   = src_used_i && (src_i != '0) && ent_valid_i && ent_we_i && (ent_rd_i == src_i);
    assign is_load_o = match_o && ent_load_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall decision and operand-forwarding selects for stage A.
// Define HAZARD_FWD_EN to enable forwarding; otherwise dependents wait for W.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int REG_W      = 5
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             d_valid_i,
    input  logic [REG_W-1:0] d_rs1_i,
    input  logic [REG_W-1:0] d_rs2_i,
    input  logic             d_rs1_used_i,
    input  logic             d_rs2_used_i,
    input  logic [REG_W-1:0] d_rd_i,
    input  logic             d_rd_we_i,
    input  logic             d_is_load_i,
    input  logic             d_is_mul_i,
    input  logic             br_en_i,
    output logic             d_ready_o,
    output logic             a_issue_o,
    output logic [1:0]       a_fwd_rs1_o,
    output logic [1:0]       a_fwd_rs2_o,
    output logic             a_busy_o
);

    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } sb_entry_t;

    sb_entry_t [2:0]  ent_q, ent_d;   // index 0 = A, 1 = C, 2 = W
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, issue_q;
    fwd_sel_e         fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    fwd_sel_e         sel1_s, sel2_s;
    logic [2:0]       m1_s, m2_s, l1_s, l2_s;
    logic             load_use_s, hazard_s, stall_s, issue_s;

    for (genvar e = 0; e < 3; e++) begin : g_match
        hz_match #(.REG_W(REG_W)) u_rs1 (
            .src_i       (d_rs1_i),
            .src_used_i  (d_rs1_used_i),
            .ent_valid_i (ent_q[e].valid),
            .ent_rd_i    (ent_q[e].rd),
            .ent_we_i    (ent_q[e].we),
            .ent_load_i  (ent_q[e].is_load),
            .match_o     (m1_s[e]),
            .is_load_o   (l1_s[e])
        );
        hz_match #(.REG_W(REG_W)) u_rs2 (
            .src_i       (d_rs2_i),
            .src_used_i  (d_rs2_used_i),
            .ent_valid_i (ent_q[e].valid),
            .ent_rd_i    (ent_q[e].rd),
            .ent_we_i    (ent_q[e].we),
            .ent_load_i  (ent_q[e].is_load),
            .match_o     (m2_s[e]),
            .is_load_o   (l2_s[e])
        );
    end

    // Load data only exists once the load has left A.
    assign load_use_s = |((l1_s | l2_s) & ENT_A_MASK);

`ifdef HAZARD_FWD_EN
    assign hazard_s = load_use_s;
    assign sel1_s   = fwd_pick(m1_s);
    assign sel2_s   = fwd_pick(m2_s);
`else
    assign hazard_s = (|((m1_s | m2_s) & NOFWD_STALL_MASK)) | load_use_s;
    assign sel1_s   = FWD_REG;
    assign sel2_s   = FWD_REG;
`endif

    assign stall_s   = busy_q | (d_valid_i & hazard_s);
    assign d_ready_o = br_en_i | ~stall_s;
    assign issue_s   = d_valid_i & ~stall_s & ~br_en_i;

    // Scoreboard shift, MUL occupancy counter and next A-stage selects.
    always_comb begin
        ent_d  = ent_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        fwd1_d = issue_s ? sel1_s : FWD_REG;
        fwd2_d = issue_s ? sel2_s : FWD_REG;
        ent_d[2] = ent_q[1];
        if (busy_q) begin
            ent_d[1] = '0;
            cnt_d    = cnt_q - CNT_W'(1);
            busy_d   = (cnt_q != CNT_W'(1));
        end else begin
            ent_d[1] = ent_q[0];
            if (issue_s) begin
                ent_d[0] = '{valid: 1'b1, rd: d_rd_i, we: d_rd_we_i, is_load: d_is_load_i};
                if (d_is_mul_i) begin
                    cnt_d  = CNT_W'(MUL_CYCLES - 1);
                    busy_d = 1'b1;
                end else begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end
            end else begin
                ent_d[0] = '0;
            end
        end
    end

    // State and registered A-stage outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ent_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            issue_q <= 1'b0;
            fwd1_q  <= FWD_REG;
            fwd2_q  <= FWD_REG;
        end else begin
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            issue_q <= issue_s;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
        end
    end

    assign a_issue_o   = issue_q;
    assign a_busy_o    = busy_q;
    assign a_fwd_rs1_o = fwd1_q;
    assign a_fwd_rs2_o = fwd2_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Cycle-table bench for hazard_ctrl; expectations follow the HAZARD_FWD_EN build.
module tb_hazard_ctrl;

    localparam logic [1:0] FR = 2'd0;
    localparam logic [1:0] FC = 2'd1;
    localparam logic [1:0] FW = 2'd2;
    // instruction kind = {br_en, is_mul, is_load, rd_we}
    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_ALU  = 4'b0001;
    localparam logic [3:0] K_LD   = 4'b0011;
    localparam logic [3:0] K_MUL  = 4'b0101;
    localparam logic [3:0] K_BRA  = 4'b1001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_valid = 1'b0, d_rs1_used = 1'b0, d_rs2_used = 1'b0;
    logic [4:0] d_rs1 = 5'd0, d_rs2 = 5'd0, d_rd = 5'd0;
    logic       d_rd_we = 1'b0, d_is_load = 1'b0, d_is_mul = 1'b0, br_en = 1'b0;
    logic       d_ready, a_issue, a_busy;
    logic [1:0] a_fwd_rs1, a_fwd_rs2;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] k;
        logic       rdy, iss;
        logic [1:0] f1, f2;
        logic       busy;
    } row_t;
    row_t tbl[$];

    hazard_ctrl #(.MUL_CYCLES(4), .REG_W(5)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .d_valid_i    (d_valid),
        .d_rs1_i      (d_rs1),
        .d_rs2_i      (d_rs2),
        .d_rs1_used_i (d_rs1_used),
        .d_rs2_used_i (d_rs2_used),
        .d_rd_i       (d_rd),
        .d_rd_we_i    (d_rd_we),
        .d_is_load_i  (d_is_load),
        .d_is_mul_i   (d_is_mul),
        .br_en_i      (br_en),
        .d_ready_o    (d_ready),
        .a_issue_o    (a_issue),
        .a_fwd_rs1_o  (a_fwd_rs1),
        .a_fwd_rs2_o  (a_fwd_rs2),
        .a_busy_o     (a_busy)
    );

    always #5 clk = ~clk;

    task automatic row(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] k, input logic rdy, input logic iss, input logic [1:0] f1,
                       input logic [1:0] f2, input logic busy);
        row_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.k = k;
        r.rdy = rdy; r.iss = iss; r.f1 = f1; r.f2 = f2; r.busy = busy;
        tbl.push_back(r);
    endtask

    task automatic bub(input int n);
        for (int j = 0; j < n; j++) row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b0, FR, FR, 1'b0);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [3:0] k);
        d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
        d_rs1_used = 1'b1; d_rs2_used = 1'b1;
        d_rd_we = k[0]; d_is_load = k[1]; d_is_mul = k[2]; br_en = k[3];
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic iss, input logic [1:0] f1,
                           input logic [1:0] f2, input logic busy);
        chk({tag, ".d_ready"}, {1'b0, d_ready}, {1'b0, rdy});
        chk({tag, ".a_issue"}, {1'b0, a_issue}, {1'b0, iss});
        chk({tag, ".fwd_rs1"}, a_fwd_rs1, f1);
        chk({tag, ".fwd_rs2"}, a_fwd_rs2, f2);
        chk({tag, ".a_busy"}, {1'b0, a_busy}, {1'b0, busy});
    endtask

    initial begin
        // A: ALU producer x5, back-to-back consumer on rs1
        row(1'b1, 5'd1, 5'd2, 5'd5, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
`ifdef HAZARD_FWD_EN
        row(1'b1, 5'd5, 5'd3, 5'd6, K_ALU, 1'b1, 1'b1, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FC, FR, 1'b0);
`else
        row(1'b1, 5'd5, 5'd3, 5'd6, K_ALU, 1'b0, 1'b1, FR, FR, 1'b0);
        row(1'b1, 5'd5, 5'd3, 5'd6, K_ALU, 1'b0, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd5, 5'd3, 5'd6, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
`endif
        bub(2);
        // B: load x5, consumer reads it on rs2
        row(1'b1, 5'd1, 5'd2, 5'd5, K_LD, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd3, 5'd5, 5'd6, K_ALU, 1'b0, 1'b1, FR, FR, 1'b0);
`ifdef HAZARD_FWD_EN
        row(1'b1, 5'd3, 5'd5, 5'd6, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FW, 1'b0);
`else
        row(1'b1, 5'd3, 5'd5, 5'd6, K_ALU, 1'b0, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd3, 5'd5, 5'd6, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
`endif
        bub(2);
        // C: MUL x7 then dependent ADD; a stray br_en during the count is ignored
        row(1'b1, 5'd1, 5'd2, 5'd7, K_MUL, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b0, 1'b1, FR, FR, 1'b1);
        row(1'b1, 5'd7, 5'd4, 5'd8, K_BRA, 1'b1, 1'b0, FR, FR, 1'b1);
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b0, 1'b0, FR, FR, 1'b1);
`ifdef HAZARD_FWD_EN
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FC, FR, 1'b0);
`else
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b0, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b0, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd7, 5'd4, 5'd8, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
`endif
        bub(2);
        // D: x0 is never a dependency
        row(1'b1, 5'd1, 5'd2, 5'd0, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd0, 5'd0, 5'd9, K_ALU, 1'b1, 1'b1, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
        bub(2);
        // E: branch squashes dependent x6; a later reader of x6 must not see it
        row(1'b1, 5'd1, 5'd2, 5'd5, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b1, 5'd5, 5'd5, 5'd6, K_BRA, 1'b1, 1'b1, FR, FR, 1'b0);
        row(1'b1, 5'd6, 5'd6, 5'd10, K_ALU, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd0, 5'd0, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
        bub(2);
        // F: invalid D never stalls, even against a load in A
        row(1'b1, 5'd1, 5'd2, 5'd5, K_LD, 1'b1, 1'b0, FR, FR, 1'b0);
        row(1'b0, 5'd5, 5'd5, 5'd0, K_NONE, 1'b1, 1'b1, FR, FR, 1'b0);
        bub(2);

        drive(1'b0, 5'd0, 5'd0, 5'd0, K_NONE);
        repeat (2) @(posedge clk);
        #1;
        chk_all("in_reset", 1'b1, 1'b0, FR, FR, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("post_reset", 1'b1, 1'b0, FR, FR, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].k);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].iss, tbl[i].f1, tbl[i].f2, tbl[i].busy);
        end

        // Reset in the middle of a MUL count must leave no residual stall.
        @(negedge clk);
        drive(1'b1, 5'd1, 5'd2, 5'd7, K_MUL);
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd4, 5'd8, K_ALU);
        #1;
        chk_all("mul_cnt3", 1'b0, 1'b1, FR, FR, 1'b1);
        @(negedge clk);
        #1;
        chk_all("mul_cnt2", 1'b0, 1'b0, FR, FR, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_all("mid_mul_reset", 1'b1, 1'b0, FR, FR, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("after_release", 1'b1, 1'b0, FR, FR, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, K_NONE);
        #1;
        chk_all("reissue", 1'b1, 1'b1, FR, FR, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
